// File: rtl/morse_encoder.sv
`default_nettype none
// ============================================================================
// Module   : morse_encoder
// Purpose  : Sends one letter (A..Z) as ITU Morse on the LED line. Dots,
//            dashes and gaps are timed from an internal unit-tick divider.
//            A start/busy handshake accepts one letter at a time.
// Ports    : CLK     - clock
//            RESET   - asynchronous reset, active-low
//            start   - one-cycle request to send 'letter'
//            letter  - 0 = A ... 25 = Z (larger codes are ignored)
//            en      - LED output gate (timing is unaffected)
//            led     - Morse output, 1 = mark
//            busy    - high while a letter is in progress
//            done    - one-cycle pulse when a letter completes
// Revision : 1.0 - initial release
// ============================================================================
module morse_encoder #(
    parameter int CLK_DIV    = 25000000,  // CLK cycles per Morse unit (>= 2)
    parameter int DIV_W      = 25,        // unit counter width, 2**DIV_W >= CLK_DIV
    parameter int DASH_UNITS = 3          // dash length in units (2..7)
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       start,
    input  logic [4:0] letter,
    input  logic       en,
    output logic       led,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MARK = 2'd1,
        S_GAP  = 2'd2,
        S_LGAP = 2'd3
    } state_t;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [2:0]       DASH_LAST = 3'(DASH_UNITS - 1);
    localparam logic [2:0]       LGAP_LAST = 3'd2;   // letter gap is 3 units

    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [2:0]       unit_q;
    logic [1:0]       idx_q;
    logic [3:0]       pat_q;
    logic             mark_q;
    logic             busy_q;
    logic             done_q;

    logic [2:0]       rom_len;
    logic [3:0]       rom_pat;
    logic             letter_ok;
    logic             tick;
    logic [2:0]       unit_last;

    // Symbol ROM: elements are sent from pat[len-1] down to pat[0]; 1 = dash.
    always_comb begin
        rom_len = 3'd0;
        rom_pat = 4'b0000;
        case (letter)
            5'd0:  begin rom_len = 3'd2; rom_pat = 4'b0001; end // A .-
            5'd1:  begin rom_len = 3'd4; rom_pat = 4'b1000; end // B -...
            5'd2:  begin rom_len = 3'd4; rom_pat = 4'b1010; end // C -.-.
            5'd3:  begin rom_len = 3'd3; rom_pat = 4'b0100; end // D -..
            5'd4:  begin rom_len = 3'd1; rom_pat = 4'b0000; end // E .
            5'd5:  begin rom_len = 3'd4; rom_pat = 4'b0010; end // F ..-.
            5'd6:  begin rom_len = 3'd3; rom_pat = 4'b0110; end // G --.
            5'd7:  begin rom_len = 3'd4; rom_pat = 4'b0000; end // H ....
            5'd8:  begin rom_len = 3'd2; rom_pat = 4'b0000; end // I ..
            5'd9:  begin rom_len = 3'd4; rom_pat = 4'b0111; end // J .---
            5'd10: begin rom_len = 3'd3; rom_pat = 4'b0101; end // K -.-
            5'd11: begin rom_len = 3'd4; rom_pat = 4'b0100; end // L .-..
            5'd12: begin rom_len = 3'd2; rom_pat = 4'b0011; end // M --
            5'd13: begin rom_len = 3'd2; rom_pat = 4'b0010; end // N -.
            5'd14: begin rom_len = 3'd3; rom_pat = 4'b0111; end // O ---
            5'd15: begin rom_len = 3'd4; rom_pat = 4'b0110; end // P .--.
            5'd16: begin rom_len = 3'd4; rom_pat = 4'b1101; end // Q --.-
            5'd17: begin rom_len = 3'd3; rom_pat = 4'b0010; end // R .-.
            5'd18: begin rom_len = 3'd3; rom_pat = 4'b0000; end // S ...
            5'd19: begin rom_len = 3'd1; rom_pat = 4'b0001; end // T -
            5'd20: begin rom_len = 3'd3; rom_pat = 4'b0001; end // U ..-
            5'd21: begin rom_len = 3'd4; rom_pat = 4'b0001; end // V ...-
            5'd22: begin rom_len = 3'd3; rom_pat = 4'b0011; end // W .--
            5'd23: begin rom_len = 3'd4; rom_pat = 4'b1001; end // X -..-
            5'd24: begin rom_len = 3'd4; rom_pat = 4'b1011; end // Y -.--
            5'd25: begin rom_len = 3'd4; rom_pat = 4'b1100; end // Z --..
            default: begin rom_len = 3'd0; rom_pat = 4'b0000; end
        endcase
    end

    assign letter_ok = (letter <= 5'd25);
    assign tick      = (div_q == DIV_LAST);
    assign div_d     = tick ? '0 : div_q + DIV_W'(1);

    // Index of the final unit of the current state (unit counter is 0-based).
    always_comb begin
        unit_last = 3'd0;
        case (state_q)
            S_MARK:  unit_last = pat_q[idx_q] ? DASH_LAST : 3'd0;
            S_LGAP:  unit_last = LGAP_LAST;
            default: unit_last = 3'd0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            unit_q  <= 3'd0;
            idx_q   <= 2'd0;
            pat_q   <= 4'b0000;
            mark_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Divider is cleared here so the first unit is full length.
                    if (start && letter_ok) begin
                        state_q <= S_MARK;
                        busy_q  <= 1'b1;
                        mark_q  <= 1'b1;
                        pat_q   <= rom_pat;
                        idx_q   <= 2'(rom_len - 3'd1);
                        div_q   <= '0;
                        unit_q  <= 3'd0;
                    end
                end
                default: begin
                    div_q <= div_d;
                    if (tick) begin
                        if (unit_q == unit_last) begin
                            unit_q <= 3'd0;
                            case (state_q)
                                S_MARK: begin
                                    mark_q  <= 1'b0;
                                    state_q <= (idx_q == 2'd0) ? S_LGAP : S_GAP;
                                end
                                S_GAP: begin
                                    mark_q  <= 1'b1;
                                    idx_q   <= idx_q - 2'd1;
                                    state_q <= S_MARK;
                                end
                                default: begin
                                    state_q <= S_IDLE;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end
                            endcase
                        end else begin
                            unit_q <= unit_q + 3'd1;
                        end
                    end
                end
            endcase
        end
    end

    // en only gates the registered mark flag; it never touches timing.
    assign led  = mark_q & en;
    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_morse_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_morse_encoder
// Purpose  : Scoreboard bench for morse_encoder (CLK_DIV=4, DASH_UNITS=3).
//            Stimulus pushes the expected LED trace and busy length of each
//            letter; a monitor records each letter as it is sent and checks
//            it against the queue when done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_morse_encoder;

    localparam int CLK_DIV = 4;

    logic       CLK;
    logic       RESET;
    logic       start;
    logic [4:0] letter;
    logic       en;
    logic       led;
    logic       busy;
    logic       done;

    int n_vec;
    int n_fail;

    typedef struct {
        int          id;
        int          cycles;
        logic [63:0] trace;
    } exp_t;

    exp_t q[$];

    // Hand-written ITU table and letter lengths in units.
    string MORSE [26];
    int    UNITS [26];

    morse_encoder #(
        .CLK_DIV   (CLK_DIV),
        .DIV_W     (3),
        .DASH_UNITS(3)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .start (start),
        .letter(letter),
        .en    (en),
        .led   (led),
        .busy  (busy),
        .done  (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected LED trace: bit k is the LED level in cycle k+1 after acceptance.
    function automatic logic [63:0] expand(input string s);
        logic [63:0] t;
        int p;
        t = '0;
        p = 0;
        for (int i = 0; i < s.len(); i++) begin
            int u;
            u = (s[i] == 8'd45) ? 3 : 1;
            for (int j = 0; j < u * CLK_DIV; j++) begin
                if (p < 64) t[p] = 1'b1;
                p++;
            end
            p += (i == s.len() - 1) ? 3 * CLK_DIV : CLK_DIV;
        end
        return t;
    endfunction

    task automatic push_letter(input int l);
        exp_t e;
        e.id     = l;
        e.cycles = UNITS[l] * CLK_DIV;
        e.trace  = expand(MORSE[l]);
        q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Drive a one-cycle start; returns just after the sampling edge.
    task automatic send(input int l);
        @(posedge CLK); #1;
        start  = 1'b1;
        letter = 5'(l);
        @(posedge CLK); #1;
        start  = 1'b0;
    endtask

    // Wait (bounded) until done is high, sampled 1 unit after a rising edge.
    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 200) begin
            @(posedge CLK); #1;
            k++;
        end
        if (k >= 200) check({name, "_timeout"}, 0, 1);
    endtask

    // Start the next letter in the done cycle of the current one.
    task automatic send_on_done(input int l, input string name);
        wait_done(name);
        start  = 1'b1;
        letter = 5'(l);
        @(posedge CLK); #1;
        start  = 1'b0;
    endtask

    // Monitor
    initial begin : monitor
        int          cnt;
        logic [63:0] trace;
        exp_t        e;
        cnt   = 0;
        trace = '0;
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                cnt   = 0;
                trace = '0;
            end else if (busy) begin
                if (cnt < 64) trace[cnt] = led;
                cnt++;
            end else if (done) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done after %0d busy cycles, expected none", cnt);
                end else begin
                    e = q.pop_front();
                    n_vec++;
                    if (cnt != e.cycles) begin
                        n_fail++;
                        $display("FAIL busy_len letter %0d: got %0d, expected %0d", e.id, cnt, e.cycles);
                    end
                    n_vec++;
                    if (trace != e.trace) begin
                        n_fail++;
                        $display("FAIL led_trace letter %0d: got %h, expected %h", e.id, trace, e.trace);
                    end
                end
                cnt   = 0;
                trace = '0;
            end
        end
    end

    initial begin : stimulus
        exp_t e;
        int   seen;

        MORSE = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                  "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                  "..-", "...-", ".--", "-..-", "-.--", "--.."};
        UNITS = '{8, 12, 14, 10, 4, 12, 12, 10, 6, 16,
                  12, 12, 10, 8, 14, 14, 16, 10, 8, 6,
                  10, 12, 12, 14, 16, 14};

        n_vec  = 0;
        n_fail = 0;
        RESET  = 1'b0;
        start  = 1'b0;
        letter = 5'd0;
        en     = 1'b1;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check("reset_led",  int'(led),  0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        @(negedge CLK);
        RESET = 1'b1;

        // E with an ignored start (T) in cycle 5
        push_letter(4);
        send(4);
        repeat (4) @(posedge CLK);
        #1;
        start  = 1'b1;
        letter = 5'd19;
        @(posedge CLK); #1;
        start  = 1'b0;
        wait_done("E");

        // A
        push_letter(0);
        send(0);
        wait_done("A");

        // Q with en low through its second dash (cycles 17..28)
        e.id     = 16;
        e.cycles = 64;
        e.trace  = expand(MORSE[16]);
        e.trace[27:16] = 12'h000;
        q.push_back(e);
        send(16);
        repeat (16) @(posedge CLK);
        #1;
        en = 1'b0;
        repeat (12) @(posedge CLK);
        #1;
        en = 1'b1;
        wait_done("Q");

        // Back-to-back: T accepted in E's done cycle
        push_letter(4);
        push_letter(19);
        send(4);
        send_on_done(19, "E_b2b");
        wait_done("T_b2b");

        // Illegal letter codes are ignored
        for (int k = 0; k < 2; k++) begin
            send(k == 0 ? 26 : 31);
            seen = 0;
            for (int c = 0; c < 40; c++) begin
                @(posedge CLK); #1;
                if (busy || led || done) seen = 1;
            end
            check(k == 0 ? "illegal_26" : "illegal_31", seen, 0);
        end

        // Reset in cycle 10 of A; the aborted letter must not complete
        send(0);
        repeat (9) @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        check("abort_led",  int'(led),  0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        push_letter(4);
        send(4);
        wait_done("E_after_reset");

        // Full alphabet, back-to-back
        for (int l = 0; l < 26; l++) push_letter(l);
        send(0);
        for (int l = 1; l < 26; l++) send_on_done(l, "sweep");
        wait_done("sweep_last");

        repeat (20) @(posedge CLK);
        #1;
        check("queue_empty", q.size(), 0);
        check("idle_busy", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
